hs_byte_tx: RTL and testbench

- Transmitter end of the 8-bit valid/ready byte stream.
- Accepts one packed word of up to WORD_BYTES bytes plus a byte count from a host-side valid/ready port.
- Serialises the word onto the byte stream LSB-byte first, marking the final byte with out_last.
- Drives the same source-side interface that the stream's register slice consumes, so it obeys the source rules: valid never retracts, and data is held stable until accepted.

---
 rtl/hs_pkg.sv | 17 +
 rtl/hs_byte_tx_if.sv | 41 ++++
 rtl/hs_byte_tx.sv | 104 ++++++++++
 tb/tb_hs_byte_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the 8-bit valid/ready byte stream: byte width,
// transmitter state encoding and the byte-count width helper.
package hs_pkg;

    localparam int HS_BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } hs_state_e;

    // Count must reach WORD_BYTES itself, hence one bit beyond the index width.
    function automatic int hs_cnt_w(input int word_bytes);
        return $clog2(word_bytes) + 32'sd1;
    endfunction

endpackage

// File: rtl/hs_byte_tx_if.sv
// Host-word port and byte-stream port of the byte transmitter.
// The transmitter uses the slave modport; the host/sink side uses master.
interface hs_byte_tx_if #(
    parameter int WORD_BYTES = 4
);
    import hs_pkg::*;

    localparam int CNT_W = hs_cnt_w(WORD_BYTES);

    logic                            in_valid;
    logic [HS_BYTE_W*WORD_BYTES-1:0] in_data;
    logic [CNT_W-1:0]                in_nbytes;
    logic                            in_ready;
    logic                            out_valid;
    logic [HS_BYTE_W-1:0]            out_data;
    logic                            out_last;
    logic                            out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_nbytes,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        output in_nbytes,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/hs_byte_tx.sv
// Word-to-byte serialiser: accepts a packed word plus byte count and emits it
// LSB byte first on the valid/ready byte stream, flagging the final byte.
module hs_byte_tx
    import hs_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter bit BACK2BACK  = 1'b1,
    parameter int CNT_W      = hs_cnt_w(WORD_BYTES)
) (
    input  logic               clk,
    input  logic               rst,
    hs_byte_tx_if.slave        bus,
    output logic               drop,
    output logic [15:0]        words_sent
);

    localparam int              IDX_W   = $clog2(WORD_BYTES);
    localparam logic [0:0]      ST_IDLE = IDLE;
    localparam logic [0:0]      ST_SEND = SEND;
    localparam logic [CNT_W-1:0] WB_CNT = CNT_W'(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]                                 state_r;
    logic [WORD_BYTES-1:0][HS_BYTE_W-1:0]       word_r;
    logic [CNT_W-1:0]                           idx_r;
    logic [CNT_W-1:0]                           len_r;
    logic                                       drop_r;
    logic [15:0]                                words_sent_r;

    logic             sending_s;
    logic             last_s;
    logic             take_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             zero_len_s;
    logic [CNT_W-1:0] len_clamp_s;

    // Handshake decode; in_ready may follow out_ready combinationally when the
    // final byte leaves, so a new word can load without a bubble.
    always_comb begin
        sending_s = (state_r == ST_SEND);
        last_s    = sending_s && (idx_r == (len_r - CNT_ONE));
        take_s    = sending_s && bus.out_ready;

        if (rst) begin
            in_ready_s = 1'b0;
        end else if (!sending_s) begin
            in_ready_s = 1'b1;
        end else if (BACK2BACK) begin
            in_ready_s = bus.out_ready && last_s;
        end else begin
            in_ready_s = 1'b0;
        end

        accept_s   = bus.in_valid && in_ready_s;
        zero_len_s = (bus.in_nbytes == CNT_ZERO);

        if (bus.in_nbytes > WB_CNT) begin
            len_clamp_s = WB_CNT;
        end else begin
            len_clamp_s = bus.in_nbytes;
        end
    end

    // FSM and datapath registers; a new word load takes priority over the
    // return to IDLE that would otherwise follow the final byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            word_r       <= '{default: 8'h00};
            idx_r        <= CNT_ZERO;
            len_r        <= CNT_ZERO;
            drop_r       <= 1'b0;
            words_sent_r <= 16'h0000;
        end else begin
            drop_r <= accept_s && zero_len_s;

            if (take_s && last_s) begin
                words_sent_r <= words_sent_r + 16'd1;
            end

            if (accept_s && !zero_len_s) begin
                word_r  <= bus.in_data;
                len_r   <= len_clamp_s;
                idx_r   <= CNT_ZERO;
                state_r <= ST_SEND;
            end else if (take_s && last_s) begin
                state_r <= ST_IDLE;
            end else if (take_s) begin
                idx_r   <= idx_r + CNT_ONE;
            end
        end
    end

    // Byte outputs come only from registers, never from the in_* side.
    assign bus.out_valid = sending_s;
    assign bus.out_last  = last_s;
    assign bus.out_data  = sending_s ? word_r[idx_r[IDX_W-1:0]] : 8'h00;
    assign bus.in_ready  = in_ready_s;
    assign drop          = drop_r;
    assign words_sent    = words_sent_r;

endmodule

// File: tb/tb_hs_byte_tx.sv
// Self-checking bench for hs_byte_tx: directed plan steps plus random traffic
// compared against a byte-queue reference model; second instance covers BACK2BACK=0.
module tb_hs_byte_tx;
    import hs_pkg::*;

    localparam int WB = 4;
    localparam int CW = hs_cnt_w(WB);

    logic        clk = 1'b0;
    logic        rst;
    logic        rst0;
    logic        drop;
    logic        drop0;
    logic [15:0] ws;
    logic [15:0] ws0;

    always #5 clk = ~clk;

    hs_byte_tx_if #(.WORD_BYTES(WB)) bus ();
    hs_byte_tx_if #(.WORD_BYTES(WB)) bus0 ();

    hs_byte_tx #(.WORD_BYTES(WB), .BACK2BACK(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .drop(drop), .words_sent(ws)
    );

    hs_byte_tx #(.WORD_BYTES(WB), .BACK2BACK(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0), .drop(drop0), .words_sent(ws0)
    );

    // Reference model: queue of bytes still owed on the stream, {last, data}.
    logic [8:0]  q [$];
    int unsigned m_ws;
    bit          m_drop;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in_ready(input bit r, input bit ordy);
        if (r) return 1'b0;
        if (q.size() == 0) return 1'b1;
        return ordy && (q.size() == 1);
    endfunction

    // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
    task automatic step(input bit v, input logic [31:0] d, input logic [CW-1:0] n,
                        input bit ordy, input bit r, input bit do_chk);
        bit         exp_rdy;
        logic [8:0] tmp;
        int         lim;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_nbytes = n;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        exp_rdy = m_in_ready(r, ordy);
        if (do_chk) begin
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (q.size() > 0)});
            if (q.size() > 0) begin
                tmp = q[0];
                chk("out_data", {24'd0, bus.out_data}, {24'd0, tmp[7:0]});
                chk("out_last", {31'd0, bus.out_last}, {31'd0, tmp[8]});
            end else begin
                chk("out_last_idle", {31'd0, bus.out_last}, 32'd0);
            end
            chk("drop", {31'd0, drop}, {31'd0, m_drop});
            chk("words_sent", {16'd0, ws}, m_ws);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ws   = 0;
            m_drop = 1'b0;
        end else begin
            m_drop = 1'b0;
            if ((q.size() > 0) && ordy) begin
                tmp = q.pop_front();
                if (tmp[8]) m_ws = (m_ws + 1) & 32'h0000_FFFF;
            end
            if (v && exp_rdy) begin
                if (n == 0) begin
                    m_drop = 1'b1;
                end else begin
                    lim = (int'(n) > WB) ? WB : int'(n);
                    for (int k = 0; k < lim; k++) q.push_back({(k == lim - 1), d[8*k +: 8]});
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [5:0] ev0;
        logic [5:0] er0;
        logic [7:0] ed0 [6];

        // BACK2BACK=0 instance: continuous 2-byte words must take 3 cycles each.
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.in_nbytes = '0; bus.out_ready = 1'b0;
        rst0 = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = 32'h0; bus0.in_nbytes = '0; bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 32'h0000_BBAA; bus0.in_nbytes = 3'd2;
        ev0 = 6'b110110;
        er0 = 6'b001001;
        ed0 = '{8'h00, 8'hAA, 8'hBB, 8'h00, 8'hAA, 8'hBB};
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("nb2b_out_valid", {31'd0, bus0.out_valid}, {31'd0, ev0[i]});
            chk("nb2b_in_ready", {31'd0, bus0.in_ready}, {31'd0, er0[i]});
            if (ev0[i]) chk("nb2b_out_data", {24'd0, bus0.out_data}, {24'd0, ed0[i]});
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0;
        chk("nb2b_words_sent", {16'd0, ws0}, 32'd2);
        chk("nb2b_drop", {31'd0, drop0}, 32'd0);

        // Reset state of the main instance.
        q.delete(); m_ws = 0; m_drop = 1'b0;
        step(1'b1, 32'h0, 3'd1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_out_data", {24'd0, bus.out_data}, 32'd0);

        // Plain 4-byte word, sink always ready.
        step(1'b1, 32'h4433_2211, 3'd4, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("first_word_count", {16'd0, ws}, 32'd1);

        // Same word under a stalling sink.
        step(1'b1, 32'h4433_2211, 3'd4, 1'b1, 1'b0, 1'b1);
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            for (int i = 0; i < 7; i++) step(1'b0, 32'hFFFF_FFFF, 3'd3, pat[i], 1'b0, 1'b1);
        end
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);

        // Back-to-back words: DD, CC(last) with new word loaded on the CC cycle, then 55.
        step(1'b1, 32'hAABB_CCDD, 3'd2, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("b2b_ready_on_cc", {31'd0, bus.in_ready}, 32'd1);
        step(1'b1, 32'h0000_0055, 3'd1, 1'b1, 1'b0, 1'b1);
        chk("b2b_byte_55", {24'd0, bus.out_data}, 32'h55);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("b2b_count", {16'd0, ws}, 32'd4);

        // Zero-length word and an over-long count.
        step(1'b1, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("zero_len_drop", {31'd0, drop}, 32'd1);
        step(1'b1, 32'h8765_4321, 3'd7, 1'b1, 1'b0, 1'b1);
        chk("drop_one_cycle", {31'd0, drop}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);

        // Reset after two bytes of a 4-byte word, then a fresh word from byte 0.
        step(1'b1, 32'h0D0C_0B0A, 3'd4, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 1'b1);
        chk("midword_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        step(1'b1, 32'h1D1C_1B1A, 3'd3, 1'b1, 1'b0, 1'b1);
        chk("after_rst_byte0", {24'd0, bus.out_data}, 32'h1A);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, CW'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0), 1'b1);
        end

        // Walk words_sent up to 0xFFFF with single-byte words, then wrap it.
        while (m_ws != 32'h0000_FFFF) step(1'b1, $urandom, 3'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("wrap_to_zero", {16'd0, ws}, 32'd0);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
